shared_counter_scheduler: RTL

//   Shares one WIDTH-bit adder between NUM_REQ requesters, each owning a count register.
//   A round-robin arbiter grants one request per cycle; the winner's count is updated at the next edge.
//   A sweep FSM clears all channels on demand, one channel per cycle.

---
 rtl/shared_counter_pkg.sv | 14 +
 rtl/shared_counter_scheduler_rr_arbiter.sv | 33 +++
 rtl/shared_counter_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/shared_counter_pkg.sv
// Shared types and helpers for the counter scheduler and its arbiter.
package shared_counter_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    SWEEP = 1'b1
  } sched_state_t;

  // Index width for n channels; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_counter_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import shared_counter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (enable && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_counter_scheduler.sv
// Per-channel counters updated through one shared adder, with round-robin access
// and a one-channel-per-cycle clear sweep.
module shared_counter_scheduler
  import shared_counter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_clr,
  input  logic [NUM_REQ*STEP_W-1:0] req_step,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clr_all,
  output logic [NUM_REQ*WIDTH-1:0]  cnt,
  output logic [NUM_REQ-1:0]        wrap,
  output logic                      busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  sched_state_t      state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  g;
  logic [NUM_REQ-1:0] gnt;
  logic              hs;
  logic [WIDTH-1:0]  cnt_r  [NUM_REQ];
  logic [STEP_W-1:0] step_a [NUM_REQ];
  logic [WIDTH:0]    sum;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
    assign step_a[i]             = req_step[i*STEP_W +: STEP_W];
    assign cnt[i*WIDTH +: WIDTH] = cnt_r[i];
  end

  // Grants are suppressed during reset so no handshake can be seen while rst is high.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .enable  ((state == RUN) && !rst),
    .gnt     (gnt),
    .gnt_idx (g)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  // The single shared adder; the extra MSB is the carry that drives wrap.
  assign sum = {1'b0, cnt_r[g]} + {{(WIDTH + 1 - STEP_W){1'b0}}, step_a[g]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ptr   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      wrap  <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_r[i] <= '0;
    end else begin
      wrap <= '0;
      case (state)
        RUN: begin
          if (hs) begin
            ptr <= (g == LAST) ? '0 : g + 1'b1;
            if (req_clr[g]) begin
              cnt_r[g] <= '0;
            end else begin
              cnt_r[g] <= sum[WIDTH-1:0];
              wrap[g]  <= sum[WIDTH];
            end
          end
          if (clr_all) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          cnt_r[idx] <= '0;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
